riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit for the RISC-V core's data memory interface. It accepts one load or store per request from the execute/memory stage and runs a single-outstanding req/ack transaction on the data RAM bus. For stores it generates byte enables and lane-replicated write data. For loads it returns the RAM word right-shifted so the addressed byte or halfword sits at bit 0, together with the request's MASK_SEL, and these feed the downstream load mask/sign-extend stage directly.

## Interface
- WORD_LENGTH, 32, data width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 255, maximum wait for `mem_ack` before an error response is returned.
---
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  the core presents a load or store.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  WORD_LENGTH  store data, taken from the LSBs.
- req_mask_sel  in  MASK_SEL  access size: MASK_X = word, MASK_B / MASK_B_SEXT = byte, MASK_H / MASK_H_SEXT = halfword.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  WORD_LENGTH  load data aligned to bit 0 and unmasked; 0 for stores and errors.
- rsp_mask_sel  out  MASK_SEL  captured `req_mask_sel`, passed through to the mask stage.
- rsp_err  out  1  misaligned access, SEXT select on a store, or bus timeout.
- mem_req  out  1  bus request, held until ack.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits = 0.
- mem_wdata  out  WORD_LENGTH  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  bus completion; read data valid in the same cycle.
- mem_rdata  in  WORD_LENGTH  bus read data.

## Operation
- FSM states: IDLE, BUS, RESP.
  - IDLE: accept when `req_valid`; capture we, addr, wdata, mask_sel.
  - Legal request: go to BUS.
  - Illegal request: go to RESP with the error flag set and no bus activity.
- Illegal requests:
  - halfword with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - store with MASK_B_SEXT or MASK_H_SEXT.
- Byte offset `off = addr[1:0]`.
- Stores:
  - byte: be = 4'b0001 << off, wdata = {4{d[7:0]}};
  - half: be = 4'b0011 << off, wdata = {2{d[15:0]}};
  - word: be = 4'b1111.
- Loads: be = 4'b1111, mem_we = 0.
- BUS:
  - `mem_req` is held high with stable addr, we, be, wdata.
  - On `mem_ack`: latch `mem_rdata >> (8*off)` for a load, or 0 for a store; go to RESP.
  - A wait counter increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES, drop `mem_req`, set err, force rdata to 0, go to RESP.
- RESP: `rsp_valid` = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- The upper bits of `rsp_rdata` after the shift are the RAM's upper bytes, not cleared. The mask stage clears or extends them.

## Timing
- Reset values:
  - state = IDLE, `req_ready` = 1;
  - `mem_req`, `mem_we`, `rsp_valid`, `rsp_err` = 0;
  - `mem_be` = 0, `mem_addr`, `mem_wdata`, `rsp_rdata` = 0;
  - `rsp_mask_sel` = MASK_X;
  - wait counter = 0.
- Accept at edge T. `mem_req` is high from T+1.
- Zero-wait ack in cycle T+1 gives `rsp_valid` in cycle T+2. Minimum latency is 2 cycles; throughput is one access per 3 cycles.
- Illegal request accepted at T gives `rsp_valid` with `rsp_err` in cycle T+1.
- All bus outputs are registered; there is no combinational path from `mem_ack` to `mem_*`.
- An ack arriving in IDLE or RESP, for example a late ack after a timeout, is ignored.
- Reset asserted mid-transaction:
  - `mem_req` drops asynchronously;
  - any pending response is discarded.
- Timeout boundary: with no ack, `mem_req` is high for exactly TIMEOUT_CYCLES cycles. An ack arriving in the last of those cycles wins over the timeout, with `rsp_err` = 0.

## Structure
- Shared package gains:
  - LSU_STATE enum (IDLE, BUS, RESP);
  - the existing MASK_SEL enum, reused unchanged;
  - BE_BYTE = 4'b0001, BE_HALF = 4'b0011, BE_WORD = 4'b1111.
- One sub-module, `riscv_lsu_align`: purely combinational; generates be and wdata from (mask_sel, off, wdata), and performs the load right-shift.
- Top level instantiates `riscv_lsu_align`, the FSM and the wait counter. `rsp_rdata` and `rsp_mask_sel` connect directly to the mask stage's `ram_data` and `ram_mask_sel`.

## Test plan
- **Load byte, offset 3:** addr 0x103, MASK_B_SEXT, `mem_rdata` 0x80FF_0000, ack in T+1.
  - Bus: `mem_addr` 0x100, `mem_be` 4'b1111.
  - Response at T+2: `rsp_rdata` 0x0000_0080, `rsp_mask_sel` MASK_B_SEXT.
- **Store half, offset 2:** wdata 0xDEAD_BEEF, MASK_H.
  - Bus: `mem_be` 4'b1100, `mem_wdata` 0xBEEF_BEEF, `mem_we` = 1.
  - Response: `rsp_rdata` = 0.
- **Misaligned word load:** addr 0x102.
  - No `mem_req`.
  - `rsp_valid` and `rsp_err` at T+1.
- **Store with SEXT select:** MASK_B_SEXT on a store.
  - Error response at T+1, no bus activity.
- **Timeout:** TIMEOUT_CYCLES = 4, ack never asserted.
  - `mem_req` high for 4 cycles.
  - Error response with `rsp_rdata` = 0.
  - A late ack two cycles later is ignored.
- **Reset mid-BUS:** assert `rst_n` low during a 3-cycle ack wait.
  - `mem_req` drops immediately; no `rsp_valid`.
  - After release: `req_ready` = 1, and a fresh load completes normally.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared LSU types, byte-enable patterns and request legality helpers
package riscv_lsu_pkg;
   typedef enum logic [2:0] {MASK_X, MASK_B, MASK_B_SEXT, MASK_H, MASK_H_SEXT} mask_sel_t;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   typedef enum logic [1:0] {LSU_IDLE = ST_IDLE, LSU_BUS = ST_BUS, LSU_RESP = ST_RESP} lsu_state_t;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;
   function automatic logic is_byte(mask_sel_t m);
      return m == MASK_B || m == MASK_B_SEXT;
   endfunction
   function automatic logic is_half(mask_sel_t m);
      return m == MASK_H || m == MASK_H_SEXT;
   endfunction
   function automatic logic is_sext(mask_sel_t m);
      return m == MASK_B_SEXT || m == MASK_H_SEXT;
   endfunction
   function automatic logic lsu_illegal(logic we, mask_sel_t m, logic [1:0] off);
      return (is_half(m) && off[0]) || (!is_byte(m) && !is_half(m) && off != 2'b00) || (we && is_sext(m));
   endfunction
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: store byte-enable/lane replication and load right-alignment
module riscv_lsu_align
   import riscv_lsu_pkg::*;
#(
   parameter int WORD_LENGTH = 32
) (
   input  logic                   we,
   input  mask_sel_t              mask_sel,
   input  logic [1:0]             off,
   input  logic [WORD_LENGTH-1:0] wdata,
   input  logic [1:0]             rd_off,
   input  logic [WORD_LENGTH-1:0] rdata,
   output logic [3:0]             be,
   output logic [WORD_LENGTH-1:0] wdata_rep,
   output logic [WORD_LENGTH-1:0] rdata_shift
);
   always_comb begin
      be = !we ? BE_WORD : is_byte(mask_sel) ? BE_BYTE << off : is_half(mask_sel) ? BE_HALF << off : BE_WORD;
      wdata_rep = is_byte(mask_sel) ? {4{wdata[7:0]}} : is_half(mask_sel) ? {2{wdata[15:0]}} : wdata;
      rdata_shift = rdata >> {rd_off, 3'b000};
   end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit driving the data RAM req/ack bus
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int WORD_LENGTH    = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [WORD_LENGTH-1:0] req_wdata,
   input  mask_sel_t              req_mask_sel,
   output logic                   rsp_valid,
   output logic [WORD_LENGTH-1:0] rsp_rdata,
   output mask_sel_t              rsp_mask_sel,
   output logic                   rsp_err,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic [WORD_LENGTH-1:0] mem_wdata,
   output logic [3:0]             mem_be,
   input  logic                   mem_ack,
   input  logic [WORD_LENGTH-1:0] mem_rdata
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   lsu_state_t state;
   logic [CW-1:0] cnt;
   logic [1:0] off;
   logic [3:0] be;
   logic [WORD_LENGTH-1:0] wd, rd;
   logic illegal;
   riscv_lsu_align #(.WORD_LENGTH(WORD_LENGTH)) u_align (
      .we(req_we), .mask_sel(req_mask_sel), .off(req_addr[1:0]), .wdata(req_wdata),
      .rd_off(off), .rdata(mem_rdata), .be(be), .wdata_rep(wd), .rdata_shift(rd)
   );
   assign illegal = lsu_illegal(req_we, req_mask_sel, req_addr[1:0]);
   assign req_ready = state == LSU_IDLE;
   assign rsp_valid = state == LSU_RESP;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LSU_IDLE;
         cnt <= '0;
         off <= 2'b00;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_be <= 4'b0000;
         rsp_rdata <= '0;
         rsp_mask_sel <= MASK_X;
         rsp_err <= 1'b0;
      end else begin
         case (state)
            LSU_IDLE: if (req_valid) begin
               off <= req_addr[1:0];
               rsp_mask_sel <= req_mask_sel;
               rsp_err <= illegal;
               rsp_rdata <= '0;
               cnt <= '0;
               state <= illegal ? LSU_RESP : LSU_BUS;
               if (!illegal) begin
                  mem_req <= 1'b1;
                  mem_we <= req_we;
                  mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_be <= be;
                  mem_wdata <= wd;
               end
            end
            // an ack in the final wait cycle takes priority over the timeout
            LSU_BUS: if (mem_ack) begin
               mem_req <= 1'b0;
               rsp_rdata <= mem_we ? '0 : rd;
               state <= LSU_RESP;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               mem_req <= 1'b0;
               rsp_err <= 1'b1;
               rsp_rdata <= '0;
               state <= LSU_RESP;
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: state <= LSU_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized scoreboard bench for riscv_lsu against a behavioural model
module tb_riscv_lsu;
   import riscv_lsu_pkg::*;
   localparam int TO = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
   mask_sel_t req_mask_sel = MASK_X;
   logic req_ready, rsp_valid, rsp_err, mem_req, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   mask_sel_t rsp_mask_sel;
   logic [3:0] mem_be;
   typedef struct {logic [31:0] rdata; mask_sel_t ms; logic err;} rsp_t;
   rsp_t exp_q[$];
   int checks = 0, errors = 0;

   riscv_lsu #(.WORD_LENGTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_mask_sel(req_mask_sel),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_mask_sel(rsp_mask_sel), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      rsp_t e;
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) chk("spurious_rsp", {31'b0, rsp_valid}, 32'h0);
         else begin
            e = exp_q.pop_front();
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_mask_sel", 32'(rsp_mask_sel), 32'(e.ms));
         end
      end
   end

   // d = cycles before ack within BUS (negative = never acked)
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input mask_sel_t ms, input int d, input logic [31:0] rd);
      int size, lat, reqs, k;
      logic ill, tmo;
      logic [31:0] ebe, ewd;
      rsp_t e;
      size = (ms == MASK_B || ms == MASK_B_SEXT) ? 1 : (ms == MASK_H || ms == MASK_H_SEXT) ? 2 : 4;
      ill = (addr % size != 0) || (we && (ms == MASK_B_SEXT || ms == MASK_H_SEXT));
      tmo = !ill && (d < 0 || d >= TO);
      e.err = ill || tmo;
      e.rdata = (e.err || we) ? 32'h0 : rd >> (8 * (addr % 4));
      e.ms = ms;
      ebe = we ? ((32'(1) << size) - 1) << (addr % 4) : 32'hF;
      ewd = size == 1 ? wd[7:0] * 32'h0101_0101 : size == 2 ? wd[15:0] * 32'h0001_0001 : wd;
      lat = ill ? 1 : tmo ? TO + 1 : d + 2;
      @(negedge clk);
      chk("req_ready_idle", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_mask_sel = ms;
      exp_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      reqs = 0;
      for (k = 1; k <= TO + 10; k++) begin
         @(negedge clk);
         mem_ack = (d >= 0 && k == d + 1);
         mem_rdata = mem_ack ? rd : $urandom;
         if (mem_req) begin
            reqs++;
            chk("mem_addr", mem_addr, addr & ~32'h3);
            chk("mem_be", {28'b0, mem_be}, ebe);
            chk("mem_we", {31'b0, mem_we}, {31'b0, we});
            if (we) chk("mem_wdata", mem_wdata, ewd);
         end
         if (rsp_valid) break;
      end
      chk("latency", k, lat);
      chk("req_cycles", reqs, ill ? 0 : tmo ? TO : d + 1);
      if (mem_ack) begin
         @(negedge clk);
         mem_ack = 1'b0;
      end
      if (tmo) begin
         repeat (2) @(negedge clk);
         mem_ack = 1'b1;
         @(negedge clk);
         mem_ack = 1'b0;
         chk("late_ack_req", {31'b0, mem_req}, 32'h0);
      end
   endtask

   initial begin
      logic [31:0] a;
      mask_sel_t m;
      #1;
      chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_mask_sel", 32'(rsp_mask_sel), 32'(MASK_X));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_req(1'b0, 32'h103, 32'h0, MASK_B_SEXT, 0, 32'h80FF_0000);
      do_req(1'b1, 32'h102, 32'hDEAD_BEEF, MASK_H, 1, $urandom);
      do_req(1'b0, 32'h102, 32'h0, MASK_X, 0, $urandom);
      do_req(1'b1, 32'h101, 32'h55, MASK_B_SEXT, 0, $urandom);
      do_req(1'b0, 32'h200, 32'h0, MASK_X, -1, $urandom);
      do_req(1'b0, 32'h206, 32'h0, MASK_H, TO - 1, 32'h1234_5678);
      do_req(1'b1, 32'h301, 32'hA5A5_A5C3, MASK_B, 2, $urandom);
      // reset while waiting for an ack
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_mask_sel = MASK_X;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_req_before", {31'b0, mem_req}, 32'h1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_req_async", {31'b0, mem_req}, 32'h0);
      chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      @(negedge clk);
      chk("mid_rst_ready", {31'b0, req_ready}, 32'h1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_req", {31'b0, mem_req}, 32'h0);
      do_req(1'b0, 32'h44, 32'h0, MASK_X, 1, 32'hCAFE_F00D);
      repeat (200) begin
         m = mask_sel_t'($urandom_range(0, 4));
         a = $urandom;
         if ($urandom % 2 == 1) a = a & (m == MASK_X ? ~32'h3 : (m == MASK_H || m == MASK_H_SEXT) ? ~32'h1 : ~32'h0);
         do_req(1'($urandom % 2), a, $urandom, m, $urandom_range(0, TO + 1), $urandom);
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
